// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle RV32I controller and its datapath.
// The controller owns the master modport; the datapath (or a bench) uses slave.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       N;
  logic       Z;
  logic       C;
  logic       V;
  logic       mem_ready;

  logic       mem_req;
  logic       dmem_wren;
  logic       adr_sel;
  logic       ir_wren;
  logic       pc_wren;
  logic       regfile_wren;
  logic [1:0] ALU_asel;
  logic [1:0] ALU_bsel;
  logic [1:0] result_sel;
  logic [2:0] ximm_sel;
  logic [3:0] ALU_control;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, N, Z, C, V, mem_ready,
    output mem_req, dmem_wren, adr_sel, ir_wren, pc_wren, regfile_wren,
           ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, N, Z, C, V, mem_ready,
    input  mem_req, dmem_wren, adr_sel, ir_wren, pc_wren, regfile_wren,
           ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM of the multi-cycle RV32I core: sequences one ALU and one unified memory
// through fetch/decode/execute/memory/writeback, stalling on the memory ready handshake.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_JALR2  = 4'd12, S_LUI    = 4'd13, S_AUIPC  = 4'd14, S_HALT   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] XI_I = 3'b000, XI_S = 3'b001, XI_B = 3'b010, XI_J = 3'b011, XI_U = 3'b100;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_set_illegal;
  logic       w_mem_req, w_dmem_wren, w_adr_sel, w_ir_wren, w_pc_wren, w_regfile_wren;
  logic [1:0] w_asel, w_bsel, w_result_sel;
  logic [2:0] w_ximm_sel;
  logic [3:0] w_alu;

  // Sub only exists for R-type; sra is selected by instr[30] for both R and I shifts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_r);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: op = 4'b0111;
      3'b010: op = 4'b0101;
      3'b011: op = 4'b0110;
      3'b100: op = 4'b0100;
      3'b101: op = f7b5 ? 4'b1001 : 4'b1000;
      3'b110: op = 4'b0011;
      3'b111: op = 4'b0010;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= state_t'(RESET_STATE);
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next         = r_state;
    w_set_illegal  = 1'b0;
    w_mem_req      = 1'b0;
    w_dmem_wren    = 1'b0;
    w_adr_sel      = 1'b0;
    w_ir_wren      = 1'b0;
    w_pc_wren      = 1'b0;
    w_regfile_wren = 1'b0;
    w_asel         = 2'b00;
    w_bsel         = 2'b00;
    w_result_sel   = 2'b00;
    w_ximm_sel     = XI_I;
    w_alu          = ALU_ADD;

    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_bsel       = 2'b10;
        w_result_sel = 2'b10;
        if (bus.mem_ready) begin
          w_ir_wren = 1'b1;
          w_pc_wren = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALU_out while the opcode is decoded.
        w_asel     = 2'b01;
        w_bsel     = 2'b01;
        w_ximm_sel = (bus.opcode == OP_JAL) ? XI_J : XI_B;
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_asel     = 2'b10;
        w_bsel     = 2'b01;
        w_ximm_sel = (bus.opcode == OP_STORE) ? XI_S : XI_I;
        w_next     = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_sel = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_sel   = 2'b01;
        w_regfile_wren = 1'b1;
        w_next         = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_dmem_wren = 1'b1;
        w_adr_sel   = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        w_asel = 2'b10;
        w_alu  = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
        w_next = S_ALUWB;
      end
      S_EXEC_I: begin
        w_asel = 2'b10;
        w_bsel = 2'b01;
        w_alu  = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_regfile_wren = 1'b1;
        w_next         = S_FETCH;
      end
      S_BRANCH: begin
        // C=1 means no borrow from rs1-rs2, i.e. rs1 >= rs2 unsigned.
        w_asel = 2'b10;
        w_alu  = ALU_SUB;
        w_next = S_FETCH;
        case (bus.funct3)
          3'b000: w_pc_wren = bus.Z;
          3'b001: w_pc_wren = ~bus.Z;
          3'b100: w_pc_wren = bus.N ^ bus.V;
          3'b101: w_pc_wren = ~(bus.N ^ bus.V);
          3'b110: w_pc_wren = ~bus.C;
          3'b111: w_pc_wren = bus.C;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_JAL, S_JALR2: begin
        // rd gets old_PC+4 from the live ALU while PC takes the target held in ALU_out.
        w_asel         = 2'b01;
        w_bsel         = 2'b10;
        w_result_sel   = 2'b10;
        w_regfile_wren = 1'b1;
        w_pc_wren      = 1'b1;
        w_next         = S_FETCH;
      end
      S_JALR: begin
        w_asel = 2'b10;
        w_bsel = 2'b01;
        w_next = S_JALR2;
      end
      S_LUI, S_AUIPC: begin
        w_asel         = (r_state == S_LUI) ? 2'b11 : 2'b01;
        w_bsel         = 2'b01;
        w_ximm_sel     = XI_U;
        w_result_sel   = 2'b10;
        w_regfile_wren = 1'b1;
        w_next         = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.dmem_wren    = w_dmem_wren;
  assign bus.adr_sel      = w_adr_sel;
  assign bus.ir_wren      = w_ir_wren;
  assign bus.pc_wren      = w_pc_wren;
  assign bus.regfile_wren = w_regfile_wren;
  assign bus.ALU_asel     = w_asel;
  assign bus.ALU_bsel     = w_bsel;
  assign bus.result_sel   = w_result_sel;
  assign bus.ximm_sel     = w_ximm_sel;
  assign bus.ALU_control  = w_alu;
  assign bus.illegal      = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle table of instruction sequences
// plus hand-written reset-abort and illegal-opcode sequences.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       dmem_wren;
    logic       adr_sel;
    logic       ir_wren;
    logic       pc_wren;
    logic       regfile_wren;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [1:0] rsel;
    logic [2:0] ximm;
    logic [3:0] alu;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    string      label;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] nzcv;
    logic       mr;
    ctrl_t      exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111, AU = 7'b0010111, FENCE = 7'b0001111;

  function automatic ctrl_t k(bit mreq, bit dw, bit adr, bit ir, bit pc, bit rf,
                              logic [1:0] as, logic [1:0] bs, logic [1:0] rs,
                              logic [2:0] xi, logic [3:0] alu);
    return '{mreq, dw, adr, ir, pc, rf, as, bs, rs, xi, alu, 1'b0};
  endfunction

  function automatic ctrl_t f_wait();        return k(1,0,0,0,0,0, 2'd0,2'd2,2'd2,3'd0,4'd0); endfunction
  function automatic ctrl_t f_go();          return k(1,0,0,1,1,0, 2'd0,2'd2,2'd2,3'd0,4'd0); endfunction
  function automatic ctrl_t dec(bit j);      return k(0,0,0,0,0,0, 2'd1,2'd1,2'd0,j ? 3'd3 : 3'd2,4'd0); endfunction
  function automatic ctrl_t exr(logic [3:0] a); return k(0,0,0,0,0,0, 2'd2,2'd0,2'd0,3'd0,a); endfunction
  function automatic ctrl_t exi(logic [3:0] a); return k(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd0,a); endfunction
  function automatic ctrl_t aluwb();         return k(0,0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,4'd0); endfunction
  function automatic ctrl_t madr(bit s);     return k(0,0,0,0,0,0, 2'd2,2'd1,2'd0,s ? 3'd1 : 3'd0,4'd0); endfunction
  function automatic ctrl_t mrd();           return k(1,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,4'd0); endfunction
  function automatic ctrl_t mwb();           return k(0,0,0,0,0,1, 2'd0,2'd0,2'd1,3'd0,4'd0); endfunction
  function automatic ctrl_t mwr();           return k(1,1,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,4'd0); endfunction
  function automatic ctrl_t br(bit t);       return k(0,0,0,0,t,0, 2'd2,2'd0,2'd0,3'd0,4'd1); endfunction
  function automatic ctrl_t jmp();           return k(0,0,0,0,1,1, 2'd1,2'd2,2'd2,3'd0,4'd0); endfunction
  function automatic ctrl_t jalr1();         return k(0,0,0,0,0,0, 2'd2,2'd1,2'd0,3'd0,4'd0); endfunction
  function automatic ctrl_t upper(bit lui);  return k(0,0,0,0,0,1, lui ? 2'd3 : 2'd1,2'd1,2'd2,3'd4,4'd0); endfunction

  function automatic ctrl_t halt_out();
    ctrl_t c;
    c = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t sample();
    return '{bus.mem_req, bus.dmem_wren, bus.adr_sel, bus.ir_wren, bus.pc_wren,
             bus.regfile_wren, bus.ALU_asel, bus.ALU_bsel, bus.result_sel,
             bus.ximm_sel, bus.ALU_control, bus.illegal};
  endfunction

  task automatic add(string l, logic [6:0] op, logic [2:0] f3, logic f7,
                     logic [3:0] nzcv, logic mr, ctrl_t e);
    tbl.push_back('{l, op, f3, f7, nzcv, mr, e});
  endtask

  task automatic check(string name, ctrl_t got, ctrl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got ctrl=%h expected ctrl=%h", name, got, exp);
    end
  endtask

  task automatic drive(logic [6:0] op, logic [2:0] f3, logic f7, logic [3:0] nzcv, logic mr);
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    {bus.N, bus.Z, bus.C, bus.V} = nzcv;
    bus.mem_ready = mr;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(string name, logic [6:0] op, logic [2:0] f3, logic f7,
                      logic [3:0] nzcv, logic mr, ctrl_t exp);
    drive(op, f3, f7, nzcv, mr);
    @(negedge clk);
    check(name, sample(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(7'd0, 3'd0, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // add x3,x1,x2: 4 cycles, writeback in ALUWB
    add("add_fetch", RT, 3'b000, 0, 4'd0, 1, f_go());
    add("add_dec",   RT, 3'b000, 0, 4'd0, 0, dec(0));
    add("add_exec",  RT, 3'b000, 0, 4'd0, 0, exr(4'b0000));
    add("add_wb",    RT, 3'b000, 0, 4'd0, 0, aluwb());
    // sub with a one-cycle fetch wait
    add("sub_fwait", RT, 3'b000, 1, 4'd0, 0, f_wait());
    add("sub_fetch", RT, 3'b000, 1, 4'd0, 1, f_go());
    add("sub_dec",   RT, 3'b000, 1, 4'd0, 0, dec(0));
    add("sub_exec",  RT, 3'b000, 1, 4'd0, 0, exr(4'b0001));
    add("sub_wb",    RT, 3'b000, 1, 4'd0, 0, aluwb());
    // R-type sra and sltu
    add("sra_fetch", RT, 3'b101, 1, 4'd0, 1, f_go());
    add("sra_dec",   RT, 3'b101, 1, 4'd0, 0, dec(0));
    add("sra_exec",  RT, 3'b101, 1, 4'd0, 0, exr(4'b1001));
    add("sra_wb",    RT, 3'b101, 1, 4'd0, 0, aluwb());
    add("sltu_fetch", RT, 3'b011, 0, 4'd0, 1, f_go());
    add("sltu_dec",   RT, 3'b011, 0, 4'd0, 0, dec(0));
    add("sltu_exec",  RT, 3'b011, 0, 4'd0, 0, exr(4'b0110));
    add("sltu_wb",    RT, 3'b011, 0, 4'd0, 0, aluwb());
    // I-type: srai, srli, addi with instr[30]=1 (must stay add), andi
    add("srai_fetch", IT, 3'b101, 1, 4'd0, 1, f_go());
    add("srai_dec",   IT, 3'b101, 1, 4'd0, 0, dec(0));
    add("srai_exec",  IT, 3'b101, 1, 4'd0, 0, exi(4'b1001));
    add("srai_wb",    IT, 3'b101, 1, 4'd0, 0, aluwb());
    add("srli_fetch", IT, 3'b101, 0, 4'd0, 1, f_go());
    add("srli_dec",   IT, 3'b101, 0, 4'd0, 0, dec(0));
    add("srli_exec",  IT, 3'b101, 0, 4'd0, 0, exi(4'b1000));
    add("srli_wb",    IT, 3'b101, 0, 4'd0, 0, aluwb());
    add("addi_fetch", IT, 3'b000, 1, 4'd0, 1, f_go());
    add("addi_dec",   IT, 3'b000, 1, 4'd0, 0, dec(0));
    add("addi_exec",  IT, 3'b000, 1, 4'd0, 0, exi(4'b0000));
    add("addi_wb",    IT, 3'b000, 1, 4'd0, 0, aluwb());
    add("andi_fetch", IT, 3'b111, 0, 4'd0, 1, f_go());
    add("andi_dec",   IT, 3'b111, 0, 4'd0, 0, dec(0));
    add("andi_exec",  IT, 3'b111, 0, 4'd0, 0, exi(4'b0010));
    add("andi_wb",    IT, 3'b111, 0, 4'd0, 0, aluwb());
    // lw with memory not ready for 3 cycles in MEMRD
    add("lw_fetch",  LD, 3'b010, 0, 4'd0, 1, f_go());
    add("lw_dec",    LD, 3'b010, 0, 4'd0, 0, dec(0));
    add("lw_adr",    LD, 3'b010, 0, 4'd0, 0, madr(0));
    add("lw_rd_w0",  LD, 3'b010, 0, 4'd0, 0, mrd());
    add("lw_rd_w1",  LD, 3'b010, 0, 4'd0, 0, mrd());
    add("lw_rd_w2",  LD, 3'b010, 0, 4'd0, 0, mrd());
    add("lw_rd_go",  LD, 3'b010, 0, 4'd0, 1, mrd());
    add("lw_wb",     LD, 3'b010, 0, 4'd0, 1, mwb());
    // sw, zero-wait
    add("sw_fetch",  ST, 3'b010, 0, 4'd0, 1, f_go());
    add("sw_dec",    ST, 3'b010, 0, 4'd0, 1, dec(0));
    add("sw_adr",    ST, 3'b010, 0, 4'd0, 1, madr(1));
    add("sw_wr",     ST, 3'b010, 0, 4'd0, 1, mwr());
    // branches on 1 - 0xFFFFFFFF: N=0 Z=0 C=0 (borrow) V=0
    add("bltu_fetch", BR, 3'b110, 0, 4'b0000, 1, f_go());
    add("bltu_dec",   BR, 3'b110, 0, 4'b0000, 0, dec(0));
    add("bltu_br",    BR, 3'b110, 0, 4'b0000, 0, br(1));
    add("bgeu_fetch", BR, 3'b111, 0, 4'b0000, 1, f_go());
    add("bgeu_dec",   BR, 3'b111, 0, 4'b0000, 0, dec(0));
    add("bgeu_br",    BR, 3'b111, 0, 4'b0000, 0, br(0));
    add("blt_fetch",  BR, 3'b100, 0, 4'b0000, 1, f_go());
    add("blt_dec",    BR, 3'b100, 0, 4'b0000, 0, dec(0));
    add("blt_br",     BR, 3'b100, 0, 4'b0000, 0, br(0));
    add("bge_fetch",  BR, 3'b101, 0, 4'b0000, 1, f_go());
    add("bge_dec",    BR, 3'b101, 0, 4'b0000, 0, dec(0));
    add("bge_br",     BR, 3'b101, 0, 4'b0000, 0, br(1));
    add("beq_fetch",  BR, 3'b000, 0, 4'b0110, 1, f_go());
    add("beq_dec",    BR, 3'b000, 0, 4'b0110, 0, dec(0));
    add("beq_br",     BR, 3'b000, 0, 4'b0110, 0, br(1));
    add("bne_fetch",  BR, 3'b001, 0, 4'b0110, 1, f_go());
    add("bne_dec",    BR, 3'b001, 0, 4'b0110, 0, dec(0));
    add("bne_br",     BR, 3'b001, 0, 4'b0110, 0, br(0));
    // jumps and upper-immediates
    add("jal_fetch",  JL, 3'b000, 0, 4'd0, 1, f_go());
    add("jal_dec",    JL, 3'b000, 0, 4'd0, 0, dec(1));
    add("jal_exec",   JL, 3'b000, 0, 4'd0, 0, jmp());
    add("jalr_fetch", JR, 3'b000, 0, 4'd0, 1, f_go());
    add("jalr_dec",   JR, 3'b000, 0, 4'd0, 0, dec(0));
    add("jalr_c1",    JR, 3'b000, 0, 4'd0, 0, jalr1());
    add("jalr_c2",    JR, 3'b000, 0, 4'd0, 0, jmp());
    add("lui_fetch",  LU, 3'b000, 0, 4'd0, 1, f_go());
    add("lui_dec",    LU, 3'b000, 0, 4'd0, 0, dec(0));
    add("lui_exec",   LU, 3'b000, 0, 4'd0, 0, upper(1));
    add("auipc_fetch", AU, 3'b000, 0, 4'd0, 1, f_go());
    add("auipc_dec",   AU, 3'b000, 0, 4'd0, 0, dec(0));
    add("auipc_exec",  AU, 3'b000, 0, 4'd0, 0, upper(0));
    add("after_auipc", AU, 3'b000, 0, 4'd0, 0, f_wait());

    do_reset();
    @(negedge clk);
    check("reset_state", sample(), f_wait());
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i].label, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].nzcv,
                          tbl[i].mr, tbl[i].exp);

    // Reset in MEMWR while memory stalls: write strobe must vanish immediately and stay gone.
    step("rst_sw_fetch", ST, 3'b010, 0, 4'd0, 1, f_go());
    step("rst_sw_dec",   ST, 3'b010, 0, 4'd0, 0, dec(0));
    step("rst_sw_adr",   ST, 3'b010, 0, 4'd0, 0, madr(1));
    drive(ST, 3'b010, 0, 4'd0, 0);
    @(negedge clk);
    check("rst_sw_wr_stall", sample(), mwr());
    #2 rst_n = 1'b0;
    #1 check("rst_async_abort", sample(), f_wait());
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("rst_next_fetch", ST, 3'b010, 0, 4'd0, 0, f_wait());

    // Unsupported opcode: HALT absorbs, sticky illegal, cleared only by reset.
    step("ill_fetch", FENCE, 3'b000, 0, 4'd0, 1, f_go());
    step("ill_dec",   FENCE, 3'b000, 0, 4'd0, 1, dec(0));
    for (int i = 0; i < 4; i++)
      step($sformatf("ill_halt%0d", i), RT, 3'b000, 0, 4'd0, 1, halt_out());
    do_reset();
    @(negedge clk);
    check("ill_cleared", sample(), f_wait());
    @(posedge clk);
    #1;

    // Branch with reserved funct3 also halts with illegal set.
    step("badbr_fetch", BR, 3'b010, 0, 4'd0, 1, f_go());
    step("badbr_dec",   BR, 3'b010, 0, 4'd0, 0, dec(0));
    step("badbr_br",    BR, 3'b010, 0, 4'd0, 0, br(0));
    step("badbr_halt",  BR, 3'b010, 0, 4'd0, 1, halt_out());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
